// File: rtl/ysyx_23060240_seq_ctrl.sv
// ysyx_23060240_seq_ctrl
// Multi-cycle sequencer for a simple core: fetch, decode, execute, optional
// memory access, then write-back. Trap instructions park the core in HALT.
// A memory acknowledge that never arrives parks the core in ERR.
//
// Ports
//   clk, rst       : clock and asynchronous active-high reset
//   imem_req       : instruction fetch request (FETCH only)
//   imem_ack       : instruction valid this cycle
//   inst_we        : latch the fetched instruction (FETCH with ack)
//   dec_is_load    : decoder says the latched instruction is a load
//   dec_is_store   : decoder says the latched instruction is a store
//   dec_w_en       : decoder says the instruction writes the register file
//   dec_trap       : decoder says the instruction is a trap
//   dmem_req       : data memory request (MEM only)
//   dmem_wen       : data memory write enable (MEM with a store)
//   dmem_ack       : data access complete this cycle
//   rf_we, pc_we   : register-file write and PC update strobes (WB only)
//   halted, err    : sticky trap and timeout indications
//   retired_cnt    : retired instruction count, wraps silently
//   state          : current FSM state for debug
module ysyx_23060240_seq_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        inst_we,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_w_en,
    input  logic        dec_trap,
    output logic        dmem_req,
    output logic        dmem_wen,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic        pc_we,
    output logic        halted,
    output logic        err,
    output logic [31:0] retired_cnt,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERR    = 3'd7
    } state_t;

    state_t      cur_state;
    state_t      next_state;
    logic [7:0]  wait_cnt;
    logic        timed_out;

    // The wait counter has reached its limit; only matters when no ack came.
    assign timed_out = (wait_cnt == TIMEOUT);
    assign state     = cur_state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state logic. Acks win over the timeout when both happen together.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE:   next_state = FETCH;
            FETCH: begin
                if (imem_ack)       next_state = DECODE;
                else if (timed_out) next_state = ERR;
            end
            DECODE: next_state = dec_trap ? HALT : EXEC;
            EXEC:   next_state = (dec_is_load || dec_is_store) ? MEM : WB;
            MEM: begin
                if (dmem_ack)       next_state = WB;
                else if (timed_out) next_state = ERR;
            end
            WB:     next_state = FETCH;
            HALT:   next_state = HALT;
            ERR:    next_state = ERR;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: purely state plus current inputs, so strobes line up
    // with the ack cycle that caused them.
    always_comb begin
        imem_req = 1'b0;
        inst_we  = 1'b0;
        dmem_req = 1'b0;
        dmem_wen = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        halted   = 1'b0;
        err      = 1'b0;
        case (cur_state)
            FETCH: begin
                imem_req = 1'b1;
                inst_we  = imem_ack;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_wen = dec_is_store;
            end
            WB: begin
                pc_we = 1'b1;
                rf_we = dec_w_en && !dec_is_store;
            end
            HALT:    halted = 1'b1;
            ERR:     err    = 1'b1;
            default: ;
        endcase
    end

    // Wait counter. Any state other than FETCH/MEM holds it at zero, so it is
    // already clear on entry to either waiting state; an ack also clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if ((cur_state == FETCH && !imem_ack) ||
                     (cur_state == MEM   && !dmem_ack)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // Retired instruction counter, one count per write-back cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= 32'd0;
        end else if (cur_state == WB) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_seq_ctrl.sv
// Testbench for ysyx_23060240_seq_ctrl with TIMEOUT=4.
// Each cycle the expected state and output bundle are pushed to a queue
// when inputs are driven, then popped and compared on the falling edge.
// Output bundle bit order: {imem_req, inst_we, dmem_req, dmem_wen,
//                          rf_we, pc_we, halted, err}
module tb_ysyx_23060240_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic        imem_ack;
    logic        inst_we;
    logic        dec_is_load;
    logic        dec_is_store;
    logic        dec_w_en;
    logic        dec_trap;
    logic        dmem_req;
    logic        dmem_wen;
    logic        dmem_ack;
    logic        rf_we;
    logic        pc_we;
    logic        halted;
    logic        err;
    logic [31:0] retired_cnt;
    logic [2:0]  state;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] outs;
    } exp_t;

    exp_t sbQueue[$];
    int   errCount   = 0;
    int   checkCount = 0;

    ysyx_23060240_seq_ctrl #(.TIMEOUT(8'd4)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .inst_we      (inst_we),
        .dec_is_load  (dec_is_load),
        .dec_is_store (dec_is_store),
        .dec_w_en     (dec_w_en),
        .dec_trap     (dec_trap),
        .dmem_req     (dmem_req),
        .dmem_wen     (dmem_wen),
        .dmem_ack     (dmem_ack),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .halted       (halted),
        .err          (err),
        .retired_cnt  (retired_cnt),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] outBundle();
        return {imem_req, inst_we, dmem_req, dmem_wen, rf_we, pc_we, halted, err};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        if (obs !== expv) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of acks, queue its expectation, compare on the falling
    // edge, then advance to just after the next rising edge.
    task automatic applyStimulus(input string tag, input logic ia, input logic da,
                                 input logic [2:0] expState, input logic [7:0] expOuts);
        exp_t e;
        imem_ack = ia;
        dmem_ack = da;
        sbQueue.push_back({expState, expOuts});
        @(negedge clk);
        if (sbQueue.size() == 0) begin
            checkOutput({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = sbQueue.pop_front();
            checkOutput({tag, "_state"}, {29'd0, state}, {29'd0, e.st});
            checkOutput({tag, "_outs"}, {24'd0, outBundle()}, {24'd0, e.outs});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setDecode(input logic ld, input logic st, input logic wen, input logic trap);
        dec_is_load  = ld;
        dec_is_store = st;
        dec_w_en     = wen;
        dec_trap     = trap;
    endtask

    initial begin
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        setDecode(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state
        applyStimulus("rst", 1'b1, 1'b1, 3'd0, 8'h00);
        checkOutput("rst_cnt", retired_cnt, 32'd0);
        rst = 1'b0;
        applyStimulus("idle", 1'b1, 1'b1, 3'd0, 8'h00);

        // ALU instruction, ack on first fetch cycle
        setDecode(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("alu_f",  1'b1, 1'b0, 3'd1, 8'hC0);
        applyStimulus("alu_d",  1'b0, 1'b0, 3'd2, 8'h00);
        applyStimulus("alu_e",  1'b0, 1'b0, 3'd3, 8'h00);
        applyStimulus("alu_wb", 1'b0, 1'b0, 3'd5, 8'h0C);
        checkOutput("alu_cnt", retired_cnt, 32'd1);

        // Store, dmem_ack three cycles late; stray acks must be ignored
        setDecode(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus("st_f0", 1'b0, 1'b1, 3'd1, 8'h80);
        applyStimulus("st_f1", 1'b1, 1'b0, 3'd1, 8'hC0);
        applyStimulus("st_d",  1'b0, 1'b0, 3'd2, 8'h00);
        applyStimulus("st_e",  1'b0, 1'b0, 3'd3, 8'h00);
        applyStimulus("st_m0", 1'b0, 1'b0, 3'd4, 8'h30);
        applyStimulus("st_m1", 1'b1, 1'b0, 3'd4, 8'h30);
        applyStimulus("st_m2", 1'b0, 1'b0, 3'd4, 8'h30);
        applyStimulus("st_m3", 1'b0, 1'b1, 3'd4, 8'h30);
        applyStimulus("st_wb", 1'b0, 1'b0, 3'd5, 8'h04);
        checkOutput("st_cnt", retired_cnt, 32'd2);

        // Load with immediate ack
        setDecode(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("ld_f",  1'b1, 1'b0, 3'd1, 8'hC0);
        applyStimulus("ld_d",  1'b0, 1'b0, 3'd2, 8'h00);
        applyStimulus("ld_e",  1'b0, 1'b0, 3'd3, 8'h00);
        applyStimulus("ld_m",  1'b0, 1'b1, 3'd4, 8'h20);
        applyStimulus("ld_wb", 1'b0, 1'b0, 3'd5, 8'h0C);
        checkOutput("ld_cnt", retired_cnt, 32'd3);

        // Ack on the 5th fetch cycle beats the timeout, then a trap halts
        setDecode(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("late_f", 1'b0, 1'b0, 3'd1, 8'h80);
        end
        applyStimulus("late_f4", 1'b1, 1'b0, 3'd1, 8'hC0);
        applyStimulus("trap_d",  1'b0, 1'b0, 3'd2, 8'h00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("halt", 1'b1, 1'b1, 3'd6, 8'h02);
        end
        checkOutput("halt_cnt", retired_cnt, 32'd3);

        // Asynchronous reset out of HALT, then fetch timeout into ERR
        rst = 1'b1;
        #1;
        checkOutput("arst_state", {29'd0, state}, 32'd0);
        checkOutput("arst_outs", {24'd0, outBundle()}, 32'd0);
        checkOutput("arst_cnt", retired_cnt, 32'd0);
        setDecode(1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus("idle2", 1'b0, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("to_f", 1'b0, 1'b0, 3'd1, 8'h80);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus("err", 1'b1, 1'b1, 3'd7, 8'h01);
        end

        // Reset in the middle of a load's MEM phase
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus("idle3", 1'b0, 1'b0, 3'd0, 8'h00);
        applyStimulus("r_f",   1'b1, 1'b0, 3'd1, 8'hC0);
        applyStimulus("r_d",   1'b0, 1'b0, 3'd2, 8'h00);
        applyStimulus("r_e",   1'b0, 1'b0, 3'd3, 8'h00);
        applyStimulus("r_wb",  1'b0, 1'b0, 3'd5, 8'h0C);
        checkOutput("r_cnt", retired_cnt, 32'd1);
        setDecode(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("rm_f",  1'b1, 1'b0, 3'd1, 8'hC0);
        applyStimulus("rm_d",  1'b0, 1'b0, 3'd2, 8'h00);
        applyStimulus("rm_e",  1'b0, 1'b0, 3'd3, 8'h00);
        applyStimulus("rm_m0", 1'b0, 1'b0, 3'd4, 8'h20);
        applyStimulus("rm_m1", 1'b0, 1'b0, 3'd4, 8'h20);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mrst_state", {29'd0, state}, 32'd0);
        checkOutput("mrst_outs", {24'd0, outBundle()}, 32'd0);
        checkOutput("mrst_cnt", retired_cnt, 32'd0);
        checkOutput("mrst_wait", {24'd0, dut.wait_cnt}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mrst_hold", {29'd0, state}, 32'd0);
        rst = 1'b0;
        setDecode(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("idle4",   1'b0, 1'b0, 3'd0, 8'h00);
        applyStimulus("clean_f", 1'b0, 1'b0, 3'd1, 8'h80);

        // Counter wrap from all-ones to zero
        force dut.retired_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retired_cnt;
        checkOutput("wrap_pre", retired_cnt, 32'hFFFF_FFFF);
        applyStimulus("wr_f",  1'b1, 1'b0, 3'd1, 8'hC0);
        applyStimulus("wr_d",  1'b0, 1'b0, 3'd2, 8'h00);
        applyStimulus("wr_e",  1'b0, 1'b0, 3'd3, 8'h00);
        applyStimulus("wr_wb", 1'b0, 1'b0, 3'd5, 8'h0C);
        checkOutput("wrap_cnt", retired_cnt, 32'd0);
        applyStimulus("wr_f2", 1'b0, 1'b0, 3'd1, 8'h80);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
